// File: rtl/jericalla_fetch.sv
// Instruction sequencer for the Jericalla datapath: loadable program memory,
// start/done handshake, fixed issue/hold window and optional skip-on-zero.
module jericalla_fetch #(
    parameter int AW   = 4,
    parameter int IW   = 17,
    parameter int HOLD = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic          start,
    input  logic [AW-1:0] last_addr,
    input  logic          skip_en,
    input  logic          Zflag,
    output logic [IW-1:0] Instruccion,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] mem [2**AW];
    logic [IW-1:0] ir;
    logic [CW-1:0] hold_cnt;
    logic          last_hold;
    logic          skip;
    logic          finish;
    logic [AW-1:0] pc_p1;
    logic [AW-1:0] pc_step;
    logic          idle_like;

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign last_hold = (state == S_HOLD) && (hold_cnt == '0);
    assign skip      = skip_en & Zflag;
    assign pc_p1     = pc + AW'(1);
    assign pc_step   = skip ? (pc + AW'(2)) : pc_p1;
    assign finish    = (pc == last_addr) || (skip && (pc_p1 == last_addr));

    // Memory has no reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (prog_we && idle_like) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_DONE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_HOLD;
            S_HOLD: begin
                if (last_hold) begin
                    state_nxt = finish ? S_DONE : S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            ir       <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) pc <= '0;
                S_FETCH: ir <= mem[pc];
                S_ISSUE: hold_cnt <= CW'(HOLD - 1);
                S_HOLD: begin
                    if (last_hold) begin
                        if (!finish) pc <= pc_step;
                    end else begin
                        hold_cnt <= hold_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Bit 0 (RAM write enable) only reaches the datapath during ISSUE.
    always_comb begin
        Instruccion = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_FETCH: busy = 1'b1;
            S_ISSUE: begin
                Instruccion = ir;
                busy        = 1'b1;
            end
            S_HOLD: begin
                Instruccion = {ir[IW-1:1], 1'b0};
                busy        = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/jericalla_fetch.md
# jericalla_fetch

Instruction sequencer that sits directly upstream of the Jericalla datapath and drives its 17-bit `Instruccion` bus. It holds a small loadable program memory, steps a program counter through it under a start/done handshake, and presents each instruction for a fixed number of cycles. The RAM write-enable bit is reduced to a single-cycle strobe, and the datapath's `Zflag` is sampled to optionally skip the next instruction.

## Interface
- `AW`, 4: program address width; memory depth is 2^AW.
- `IW`, 17: instruction width; matches the datapath instruction format.
- `HOLD`, 2: cycles the instruction is held after issue (≥1).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `prog_we`  in  1  program memory write strobe.
- `prog_addr`  in  AW  program memory write address.
- `prog_data`  in  IW  program memory write data.
- `start`  in  1  begin execution at address 0.
- `last_addr`  in  AW  address of the final instruction; sampled while running.
- `skip_en`  in  1  enables skip-on-zero.
- `Zflag`  in  1  zero flag returned by the datapath ALU.
- `Instruccion`  out  IW  instruction to the datapath: [16:13] RAM address, [12:9] ALU op, [8:5]/[4:1] ROM addresses, [0] RAM write enable.
- `pc`  out  AW  current program counter.
- `busy`  out  1  high in FETCH/ISSUE/HOLD.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, FETCH, ISSUE, HOLD, DONE.
- Reset: state IDLE; `pc`=0, `Instruccion`=0, `busy`=0, `done`=0; hold counter=0. Program memory is not cleared.
- Program memory writes take effect on the clock edge when `prog_we`=1 and state is IDLE or DONE. Writes in any other state are ignored.
- IDLE / DONE: `Instruccion`=0. On `start`=1, `pc`<=0 and the next state is FETCH. `done` stays high until DONE is left.
- FETCH (1 cycle): `ir`<=mem[`pc`]; `Instruccion`=0.
- ISSUE (1 cycle): `Instruccion`=`ir` in full, including bit 0. This is the only cycle in which bit 0 can be 1.
- HOLD (`HOLD` cycles): `Instruccion`={`ir`[16:1],0}.
  - On the last HOLD cycle, `Zflag` is sampled; `skip` = `skip_en` & `Zflag`.
  - If `pc`==`last_addr`, or `skip` and `pc`+1==`last_addr`, the next state is DONE and `pc` is unchanged.
  - Otherwise `pc`<=`pc`+1, or `pc`+2 when `skip`; this is mod 2^AW. The next state is FETCH.
- `start` in FETCH/ISSUE/HOLD is ignored.
- `rst` in any state forces all reset values at that edge. An in-flight write strobe is never emitted after reset.
- `last_addr` < current `pc` cannot arise from a start at 0. If the FSM reaches the top address without matching `last_addr`, `pc` wraps to 0 and execution continues.

## Timing
- `start` sampled at edge E: FETCH in cycle E+1, ISSUE in E+2, HOLD in E+3..E+2+`HOLD`.
- The next FETCH, or DONE, begins at cycle E+3+`HOLD`.
- Per-instruction period is 2+`HOLD` cycles. The first write strobe occurs 2 cycles after `start`.
- `Zflag` is combinational from `Instruccion`. It is valid by the last HOLD cycle because `Instruccion`[16:1] is stable from ISSUE onward.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- `done` rises in the cycle after the last HOLD cycle of the final instruction.

## Test plan
- Reset/idle: hold `rst` 2 cycles, then idle 5 cycles -> `Instruccion`=0, `pc`=0, `busy`=0, `done`=0 throughout.
- Single instruction: load mem[0]=17'h0448D, `last_addr`=0, pulse `start` -> `Instruccion`=17'h0448D for exactly 1 cycle, then 17'h0448C for 2 cycles, then `done`=1 and `Instruccion`=0; `busy` high for 4 cycles.
- Sequence: load mem[0..2]=17'h0448D, 17'h04000, 17'h0628F; `last_addr`=2; `skip_en`=0 -> `pc` steps 0,1,2 at 4-cycle intervals; three ISSUE cycles show the exact words; `done` after cycle 12.
- Skip: same program, `skip_en`=1, force `Zflag`=1 only while `pc`=0 -> instruction at address 1 is never issued; `pc` goes 0->2; `done` after 2 instructions. A skip from `pc`=1 with `last_addr`=2 -> DONE with `pc`=1.
- Locking: `prog_we` to mem[1] while `busy`, and `start` mid-run -> memory unchanged on re-run, no restart. After `done`, a write is accepted and a new `start` reruns from 0.
- Reset mid-op: assert `rst` during ISSUE -> `Instruccion`=0 at the next edge, state IDLE, no further write strobe; the program memory contents are still intact on re-start.
